tqvp_rejunity_vga_copper: RTL and testbench
===========================================

Name: tqvp_rejunity_vga_copper

Overview:
- Raster-synchronised register sequencer (copper) for the TinyQV VGA peripheral.
- Holds a CPU-programmed list of entries, each {scanline, register address, data}.
- On each new scanline it replays the entries whose line matches, as single-beat register writes into the VGA peripheral's register port.
- Changes palette, stride or pixel size mid-frame without CPU stalls.
- Sits between the CPU bus decode, the vga_timing retrace/frame pulses, and the VGA register-write port.

Parameters:
- ENTRIES, 8: number of table entries; power of two, 2..16.
- Y_W, 10: scanline number width.
- RA_W, 6: target register address width.
- RD_W, 16: target register data width. Y_W + RA_W + RD_W must equal 32.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cfg_we  in  1  write strobe for one table entry
- cfg_sel  in  $clog2(ENTRIES)  table entry index
- cfg_data  in  32  entry word: [31:22] line, [21:16] reg addr, [15:0] data
- ctl_we  in  1  control register write strobe
- ctl_data  in  8  [0] enable, [4:1] count (active entries, 0..ENTRIES), [7] clear sticky flags
- frame_start  in  1  one-cycle pulse at frame start (vsync edge)
- line_start  in  1  one-cycle pulse at new scanline (retrace)
- line_y  in  Y_W  scanline number, valid with line_start
- wr_valid  out  1  register write request to VGA peripheral
- wr_addr  out  RA_W  register address
- wr_data  out  RD_W  register data
- wr_ready  in  1  VGA port accepts write
- status  out  8  {overrun, missed, done, busy, ptr[3:0]}
- irq  out  1  list-done interrupt; only with COPPER_IRQ_EN

Behaviour:
- Reset: state IDLE; ptr=0; enable=0; count=0; overrun, missed, done all 0. Outputs wr_valid, wr_addr, wr_data, status and irq are 0. Table contents are not reset.
- Software keeps entries sorted by ascending line. The block does not sort.
- States and transitions:
  - IDLE: on line_start with enable=1, latch cur_y=line_y and go to SCAN.
  - SCAN: one compare per cycle on entry[ptr].
    - ptr==count: go to DONE, set done.
    - line==cur_y: load wr_addr/wr_data registers, go to ISSUE.
    - line<cur_y: ptr++, set missed, stay in SCAN.
    - line>cur_y: go to IDLE.
  - ISSUE: wr_valid=1. wr_addr/wr_data stay stable until the beat where wr_valid&&wr_ready. On that beat: ptr++, go to SCAN.
  - DONE: ignore line_start until frame_start.
- Latency: with the first entry matching, wr_valid rises at the second clock edge after the line_start edge. Each further matching entry takes 2 cycles per accepted write (SCAN + ISSUE).
- frame_start, outside ISSUE: ptr=0, done=0, go to IDLE. If line_start coincides, use that line_start: latch y, go to SCAN with ptr=0.
- frame_start during ISSUE: record as pending. The write completes, then the pending frame_start is applied instead of SCAN. wr_valid is never dropped before acceptance.
- line_start in SCAN or ISSUE: set overrun. cur_y is re-latched. The pending write still completes, and scanning continues with the new cur_y.
- enable=0 (via ctl_we): finishes any ISSUE in progress, then stays in IDLE. ptr is kept.
- ctl_we with bit7=1: clears overrun, missed and done, and irq. enable and count update in the same write.
- count > ENTRIES: clamp to ENTRIES. count=0: the first SCAN goes straight to DONE.
- cfg_we during ISSUE on the entry being issued: the output is unaffected (registered). The new value is seen on the next frame.
- status: busy = state is SCAN or ISSUE.
- Arithmetic: ptr is $clog2(ENTRIES)+1 bits and never wraps within a frame. Line compares are unsigned, Y_W bits.

Optional Feature:
COPPER_IRQ_EN.
- Defined:
  - irq is set on the transition into DONE.
  - Cleared by ctl_we with bit7=1, or by frame_start.
  - Set has priority over clear in the same cycle.
- Undefined: irq is tied to 0 and no flop is inferred.

Decomposition:
- Package tqvp_vga_copper_pkg:
  - state enum (IDLE, SCAN, ISSUE, DONE);
  - cfg_data field bit positions;
  - ctl bit indices;
  - status bit indices.
- Sub-module tqvp_vga_copper_table:
  - ENTRIES x 32 register file;
  - one synchronous write port, one combinational read port indexed by ptr.
- FSM, flags and output registers stay in the top module.

Test Plan:
- Reset: assert rst 2 cycles, with wr_ready=1 and stimulus idle -> wr_valid=0, status=8'h00, irq=0.
- Single write: entry0={line 5, addr 6'h30, data 16'h0015}, count=1, enable=1; then frame_start; then line_start with y=5 -> one beat, wr_valid at +2 cycles, wr_addr=6'h30, wr_data=16'h0015; then status.done=1, ptr=1, irq=1 (IRQ_EN).
- Backpressure: entries 0 and 1 both on line 10 (data 16'h0001 and 16'h0002); wr_ready low for 3 cycles -> wr_valid and data 16'h0001 held stable 4 cycles; 16'h0002 issued 2 cycles after acceptance.
- Missed entry: entry0 line 3, entry1 line 9; first line_start has y=7 -> entry0 skipped, missed=1; the write for entry1 occurs at y=9 only.
- Overrun: wr_ready held low while a second line_start arrives -> overrun=1; pending write still delivered exactly once.
- Frame restart: frame_start during ISSUE -> write completes, ptr=0, done=0; next frame re-issues entry0 on its line. ctl_data=8'h80 clears all flags.

Source files
------------

// File: rtl/tqvp_rejunity_vga_copper_pkg.sv
// Shared state encoding and bit positions for the VGA copper.
// Entry word layout: [31:22] scanline, [21:16] register address, [15:0] data.
package tqvp_vga_copper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } copper_state_e;

  localparam int CFG_W        = 32;
  localparam int CFG_LINE_LSB = 22;
  localparam int CFG_ADDR_LSB = 16;
  localparam int CFG_DATA_LSB = 0;

  localparam int CTL_EN      = 0;
  localparam int CTL_CNT_LSB = 1;
  localparam int CTL_CNT_W   = 4;
  localparam int CTL_CLR     = 7;

  localparam int STS_OVERRUN = 7;
  localparam int STS_MISSED  = 6;
  localparam int STS_DONE    = 5;
  localparam int STS_BUSY    = 4;
  localparam int STS_PTR_LSB = 0;
  localparam int STS_PTR_W   = 4;

endpackage

// File: rtl/tqvp_rejunity_vga_copper_if.sv
// Single-beat valid/ready register-write port from the copper into the VGA peripheral.
interface tqvp_rejunity_vga_copper_if #(
  parameter int RA_W = 6,
  parameter int RD_W = 16
);
  logic            wr_valid;
  logic [RA_W-1:0] wr_addr;
  logic [RD_W-1:0] wr_data;
  logic            wr_ready;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/tqvp_rejunity_vga_copper_table.sv
// Copper entry table: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; software loads them before enabling.
module tqvp_vga_copper_table #(
  parameter int ENTRIES = 8,
  parameter int W       = 32
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(ENTRIES)-1:0] wr_idx,
  input  logic [W-1:0]               wr_data,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx,
  output logic [W-1:0]               rd_data
);

  logic [W-1:0] mem_q [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/tqvp_rejunity_vga_copper.sv
// Raster-synchronised register sequencer: replays table entries matching the current
// scanline as register writes. Optional list-done interrupt under COPPER_IRQ_EN.
module tqvp_rejunity_vga_copper
  import tqvp_vga_copper_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int Y_W     = 10,
  parameter int RA_W    = 6,
  parameter int RD_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(ENTRIES)-1:0] cfg_sel,
  input  logic [CFG_W-1:0]           cfg_data,
  input  logic                       ctl_we,
  input  logic [7:0]                 ctl_data,
  input  logic                       frame_start,
  input  logic                       line_start,
  input  logic [Y_W-1:0]             line_y,
  tqvp_rejunity_vga_copper_if.master wr_if,
  output logic [7:0]                 status,
  output logic                       irq
);

  localparam int SEL_W = $clog2(ENTRIES);
  localparam int PTR_W = SEL_W + 1;

  copper_state_e    state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] ptr_inc;
  logic             enable_q, enable_d;
  logic [Y_W-1:0]   cur_y_q, cur_y_d;
  logic [Y_W-1:0]   scan_y;
  logic             overrun_q, overrun_d;
  logic             missed_q, missed_d;
  logic             done_q, done_d;
  logic             frame_pend_q, frame_pend_d;
  logic [RA_W-1:0]  wr_addr_q, wr_addr_d;
  logic [RD_W-1:0]  wr_data_q, wr_data_d;
  logic [CFG_W-1:0] entry;
  logic [Y_W-1:0]   entry_line;
  logic [CTL_CNT_W-1:0] ctl_count;
  logic             restart;
  logic             unused_ctl;

  tqvp_vga_copper_table #(
    .ENTRIES (ENTRIES),
    .W       (CFG_W)
  ) u_table (
    .clk     (clk),
    .we      (cfg_we),
    .wr_idx  (cfg_sel),
    .wr_data (cfg_data),
    .rd_idx  (ptr_q[SEL_W-1:0]),
    .rd_data (entry)
  );

  assign entry_line = entry[CFG_LINE_LSB +: Y_W];
  assign ctl_count  = ctl_data[CTL_CNT_LSB +: CTL_CNT_W];
  assign ptr_inc    = ptr_q + PTR_W'(1);
  assign unused_ctl = ^ctl_data[6:5];

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    count_d      = count_q;
    enable_d     = enable_q;
    cur_y_d      = cur_y_q;
    overrun_d    = overrun_q;
    missed_d     = missed_q;
    done_d       = done_q;
    frame_pend_d = frame_pend_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    scan_y       = cur_y_q;
    restart      = 1'b0;

    // Clears are applied first so that flag sets from the FSM win in the same cycle.
    if (ctl_we) begin
      enable_d = ctl_data[CTL_EN];
      count_d  = (32'(ctl_count) > ENTRIES) ? PTR_W'(ENTRIES) : PTR_W'(ctl_count);
      if (ctl_data[CTL_CLR]) begin
        overrun_d = 1'b0;
        missed_d  = 1'b0;
        done_d    = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (line_start && enable_q) begin
          cur_y_d = line_y;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // A late retrace replaces the line being scanned immediately.
        if (line_start) begin
          overrun_d = 1'b1;
          cur_y_d   = line_y;
          scan_y    = line_y;
        end
        if (!enable_q) begin
          state_d = IDLE;
        end else if (ptr_q >= count_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (entry_line == scan_y) begin
          wr_addr_d = entry[CFG_ADDR_LSB +: RA_W];
          wr_data_d = entry[CFG_DATA_LSB +: RD_W];
          state_d   = ISSUE;
        end else if (entry_line < scan_y) begin
          ptr_d    = ptr_inc;
          missed_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (line_start) begin
          overrun_d = 1'b1;
          cur_y_d   = line_y;
        end
        if (frame_start) begin
          frame_pend_d = 1'b1;
        end
        if (wr_if.wr_ready) begin
          ptr_d   = ptr_inc;
          state_d = enable_q ? SCAN : IDLE;
        end
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase

    // A frame boundary never cuts a write short: during ISSUE it waits for acceptance.
    if (state_q == ISSUE) begin
      restart = wr_if.wr_ready && (frame_start || frame_pend_q);
    end else begin
      restart = frame_start;
    end

    if (restart) begin
      ptr_d        = '0;
      done_d       = 1'b0;
      frame_pend_d = 1'b0;
      state_d      = IDLE;
      if (line_start && enable_q) begin
        cur_y_d = line_y;
        state_d = SCAN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      count_q      <= '0;
      enable_q     <= 1'b0;
      cur_y_q      <= '0;
      overrun_q    <= 1'b0;
      missed_q     <= 1'b0;
      done_q       <= 1'b0;
      frame_pend_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      enable_q     <= enable_d;
      cur_y_q      <= cur_y_d;
      overrun_q    <= overrun_d;
      missed_q     <= missed_d;
      done_q       <= done_d;
      frame_pend_q <= frame_pend_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_if.wr_valid = (state_q == ISSUE);
  assign wr_if.wr_addr  = wr_addr_q;
  assign wr_if.wr_data  = wr_data_q;

  always_comb begin
    status = '0;
    status[STS_OVERRUN] = overrun_q;
    status[STS_MISSED]  = missed_q;
    status[STS_DONE]    = done_q;
    status[STS_BUSY]    = (state_q == SCAN) || (state_q == ISSUE);
    status[STS_PTR_LSB +: STS_PTR_W] = STS_PTR_W'(ptr_q);
  end

`ifdef COPPER_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (frame_start || (ctl_we && ctl_data[CTL_CLR])) begin
      irq_d = 1'b0;
    end
    if ((state_d == DONE) && (state_q != DONE)) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_tqvp_rejunity_vga_copper.sv
// Directed bench for the VGA copper: one task per scenario, inline checks at the falling edge.
module tb_tqvp_rejunity_vga_copper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_sel = '0;
  logic [31:0] cfg_data = '0;
  logic        ctl_we = 1'b0;
  logic [7:0]  ctl_data = '0;
  logic        frame_start = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  line_y = '0;
  logic [7:0]  status;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;
  int beats = 0;
  int b0;

`ifdef COPPER_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  tqvp_rejunity_vga_copper_if #(.RA_W(6), .RD_W(16)) wr_if ();

  tqvp_rejunity_vga_copper #(
    .ENTRIES (8),
    .Y_W     (10),
    .RA_W    (6),
    .RD_W    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
    .ctl_we      (ctl_we),
    .ctl_data    (ctl_data),
    .frame_start (frame_start),
    .line_start  (line_start),
    .line_y      (line_y),
    .wr_if       (wr_if),
    .status      (status),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_if.wr_valid && wr_if.wr_ready) beats++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_entry(input int idx, input logic [9:0] ln, input logic [5:0] a,
                             input logic [15:0] d);
    cfg_sel  = 3'(idx);
    cfg_data = {ln, a, d};
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic write_ctl(input logic [7:0] v);
    ctl_data = v;
    ctl_we   = 1'b1;
    tick();
    ctl_we   = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pulse_line(input logic [9:0] y);
    line_y     = y;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_if.wr_ready = 1'b1;
    repeat (2) tick();
    vectors++; if (wr_if.wr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", wr_if.wr_valid); end
    vectors++; if (wr_if.wr_addr !== 6'h00) begin miscompares++; $display("FAIL reset_addr: got %h expected 00", wr_if.wr_addr); end
    vectors++; if (wr_if.wr_data !== 16'h0000) begin miscompares++; $display("FAIL reset_data: got %h expected 0000", wr_if.wr_data); end
    vectors++; if (status !== 8'h00) begin miscompares++; $display("FAIL reset_status: got %h expected 00", status); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b expected 0", irq); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    write_entry(0, 10'd5, 6'h30, 16'h0015);
    write_ctl(8'h03);
    pulse_frame();
    b0 = beats;
    pulse_line(10'd5);
    vectors++; if (wr_if.wr_valid !== 1'b0 || status !== 8'h10) begin miscompares++; $display("FAIL single_scan: got valid=%b status=%h expected valid=0 status=10", wr_if.wr_valid, status); end
    tick();
    vectors++; if (wr_if.wr_valid !== 1'b1) begin miscompares++; $display("FAIL single_latency: got valid=%b expected 1", wr_if.wr_valid); end
    vectors++; if (wr_if.wr_addr !== 6'h30 || wr_if.wr_data !== 16'h0015) begin miscompares++; $display("FAIL single_beat: got %h/%h expected 30/0015", wr_if.wr_addr, wr_if.wr_data); end
    tick();
    vectors++; if (wr_if.wr_valid !== 1'b0 || status !== 8'h11) begin miscompares++; $display("FAIL single_after: got valid=%b status=%h expected valid=0 status=11", wr_if.wr_valid, status); end
    tick();
    vectors++; if (status !== 8'h21) begin miscompares++; $display("FAIL single_done: got %h expected 21", status); end
    vectors++; if (irq !== IRQ_ON) begin miscompares++; $display("FAIL single_irq: got %b expected %b", irq, IRQ_ON); end
    pulse_line(10'd5);
    tick();
    vectors++; if (status !== 8'h21 || (beats - b0) != 1) begin miscompares++; $display("FAIL single_done_hold: got status=%h beats=%0d expected 21/1", status, beats - b0); end
    $display("test_single done");
  endtask

  task automatic test_backpressure();
    write_entry(0, 10'd10, 6'h01, 16'h0001);
    write_entry(1, 10'd10, 6'h02, 16'h0002);
    write_ctl(8'h85);
    pulse_frame();
    b0 = beats;
    wr_if.wr_ready = 1'b0;
    pulse_line(10'd10);
    tick();
    vectors++; if (wr_if.wr_valid !== 1'b1 || wr_if.wr_data !== 16'h0001) begin miscompares++; $display("FAIL bp_hold1: got %b/%h expected 1/0001", wr_if.wr_valid, wr_if.wr_data); end
    // Rewriting the entry being issued must not disturb the held beat.
    write_entry(0, 10'd10, 6'h01, 16'hffff);
    vectors++; if (wr_if.wr_valid !== 1'b1 || wr_if.wr_data !== 16'h0001) begin miscompares++; $display("FAIL bp_hold2: got %b/%h expected 1/0001", wr_if.wr_valid, wr_if.wr_data); end
    tick();
    vectors++; if (wr_if.wr_valid !== 1'b1 || wr_if.wr_data !== 16'h0001) begin miscompares++; $display("FAIL bp_hold3: got %b/%h expected 1/0001", wr_if.wr_valid, wr_if.wr_data); end
    tick();
    vectors++; if (wr_if.wr_valid !== 1'b1 || wr_if.wr_data !== 16'h0001) begin miscompares++; $display("FAIL bp_hold4: got %b/%h expected 1/0001", wr_if.wr_valid, wr_if.wr_data); end
    wr_if.wr_ready = 1'b1;
    tick();
    vectors++; if (wr_if.wr_valid !== 1'b0 || status !== 8'h11) begin miscompares++; $display("FAIL bp_accept: got valid=%b status=%h expected 0/11", wr_if.wr_valid, status); end
    tick();
    vectors++; if (wr_if.wr_valid !== 1'b1 || wr_if.wr_addr !== 6'h02 || wr_if.wr_data !== 16'h0002) begin miscompares++; $display("FAIL bp_second: got %b/%h/%h expected 1/02/0002", wr_if.wr_valid, wr_if.wr_addr, wr_if.wr_data); end
    repeat (2) tick();
    vectors++; if (status !== 8'h22 || (beats - b0) != 2) begin miscompares++; $display("FAIL bp_done: got status=%h beats=%0d expected 22/2", status, beats - b0); end
    $display("test_backpressure done");
  endtask

  task automatic test_missed();
    write_entry(0, 10'd3, 6'h05, 16'h0aaa);
    write_entry(1, 10'd9, 6'h06, 16'h0bbb);
    write_ctl(8'h85);
    pulse_frame();
    b0 = beats;
    pulse_line(10'd7);
    tick();
    vectors++; if (status !== 8'h51 || wr_if.wr_valid !== 1'b0) begin miscompares++; $display("FAIL missed_skip: got status=%h valid=%b expected 51/0", status, wr_if.wr_valid); end
    tick();
    vectors++; if (status !== 8'h41) begin miscompares++; $display("FAIL missed_idle: got %h expected 41", status); end
    pulse_line(10'd8);
    repeat (2) tick();
    vectors++; if ((beats - b0) != 0 || status !== 8'h41) begin miscompares++; $display("FAIL missed_early: got beats=%0d status=%h expected 0/41", beats - b0, status); end
    pulse_line(10'd9);
    tick();
    vectors++; if (wr_if.wr_valid !== 1'b1 || wr_if.wr_addr !== 6'h06 || wr_if.wr_data !== 16'h0bbb) begin miscompares++; $display("FAIL missed_beat: got %b/%h/%h expected 1/06/0bbb", wr_if.wr_valid, wr_if.wr_addr, wr_if.wr_data); end
    repeat (2) tick();
    vectors++; if (status !== 8'h62 || (beats - b0) != 1) begin miscompares++; $display("FAIL missed_done: got status=%h beats=%0d expected 62/1", status, beats - b0); end
    $display("test_missed done");
  endtask

  task automatic test_overrun();
    write_entry(0, 10'd20, 6'h10, 16'h1234);
    write_entry(1, 10'd40, 6'h11, 16'h5678);
    write_ctl(8'h85);
    pulse_frame();
    b0 = beats;
    wr_if.wr_ready = 1'b0;
    pulse_line(10'd20);
    tick();
    pulse_line(10'd21);
    vectors++; if (status !== 8'h90 || wr_if.wr_valid !== 1'b1 || wr_if.wr_data !== 16'h1234) begin miscompares++; $display("FAIL overrun_flag: got status=%h valid=%b data=%h expected 90/1/1234", status, wr_if.wr_valid, wr_if.wr_data); end
    wr_if.wr_ready = 1'b1;
    repeat (2) tick();
    vectors++; if (wr_if.wr_valid !== 1'b0 || status !== 8'h81 || (beats - b0) != 1) begin miscompares++; $display("FAIL overrun_once: got valid=%b status=%h beats=%0d expected 0/81/1", wr_if.wr_valid, status, beats - b0); end
    write_ctl(8'h85);
    vectors++; if (status !== 8'h01) begin miscompares++; $display("FAIL overrun_clear: got %h expected 01", status); end
    $display("test_overrun done");
  endtask

  task automatic test_frame_restart();
    write_entry(0, 10'd4, 6'h21, 16'hc0de);
    write_ctl(8'h83);
    pulse_frame();
    b0 = beats;
    wr_if.wr_ready = 1'b0;
    pulse_line(10'd4);
    tick();
    pulse_frame();
    vectors++; if (wr_if.wr_valid !== 1'b1 || status !== 8'h10) begin miscompares++; $display("FAIL restart_hold: got valid=%b status=%h expected 1/10", wr_if.wr_valid, status); end
    wr_if.wr_ready = 1'b1;
    tick();
    vectors++; if (wr_if.wr_valid !== 1'b0 || status !== 8'h00 || (beats - b0) != 1) begin miscompares++; $display("FAIL restart_apply: got valid=%b status=%h beats=%0d expected 0/00/1", wr_if.wr_valid, status, beats - b0); end
    pulse_line(10'd4);
    tick();
    vectors++; if (wr_if.wr_valid !== 1'b1 || wr_if.wr_data !== 16'hc0de) begin miscompares++; $display("FAIL restart_reissue: got %b/%h expected 1/c0de", wr_if.wr_valid, wr_if.wr_data); end
    repeat (2) tick();
    vectors++; if (status !== 8'h21 || irq !== IRQ_ON || (beats - b0) != 2) begin miscompares++; $display("FAIL restart_done: got status=%h irq=%b beats=%0d expected 21/%b/2", status, irq, beats - b0, IRQ_ON); end
    write_ctl(8'h80);
    vectors++; if (status !== 8'h01 || irq !== 1'b0) begin miscompares++; $display("FAIL restart_clear: got status=%h irq=%b expected 01/0", status, irq); end
    $display("test_frame_restart done");
  endtask

  task automatic test_count_zero();
    write_ctl(8'h81);
    pulse_frame();
    b0 = beats;
    pulse_line(10'd0);
    tick();
    vectors++; if (status !== 8'h20 || irq !== IRQ_ON || wr_if.wr_valid !== 1'b0 || (beats - b0) != 0) begin miscompares++; $display("FAIL count_zero: got status=%h irq=%b valid=%b expected 20/%b/0", status, irq, wr_if.wr_valid, IRQ_ON); end
    $display("test_count_zero done");
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 8; i++) begin
      write_entry(i, 10'(100 + i), 6'(i), 16'(i));
    end
    write_ctl(8'h9F);
    pulse_frame();
    b0 = beats;
    pulse_line(10'd200);
    repeat (10) tick();
    vectors++; if (status !== 8'h68 || (beats - b0) != 0) begin miscompares++; $display("FAIL clamp: got status=%h beats=%0d expected 68/0", status, beats - b0); end
    vectors++; if (irq !== IRQ_ON) begin miscompares++; $display("FAIL clamp_irq: got %b expected %b", irq, IRQ_ON); end
    $display("test_clamp done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_missed();
    test_overrun();
    test_frame_restart();
    test_count_zero();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
